// File: rtl/uart_cmd_ctrl.sv
// Purpose: decodes strobed 7-bit user commands into TX bytes, prescaler, config, soft reset and readback.
// Latency: every command effect is registered (visible one cycle after the strobe edge); io_out8 lags state by one more cycle.
// Backpressure: io_txValid/io_txReady handshake on the TX queue; a push into a full queue with no pop is dropped and sets sticky overflow.
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   io_in7, io_strobe      - command word {payload[4:0], opcode[1:0]} and its rising-edge qualified strobe
//   io_txValid/Ready/Data  - TX byte queue head, valid/ready drained
//   io_prediv              - committed prescaler value
//   io_resetCommandStrobe  - one-cycle soft-reset pulse
//   io_gatedTxdStopBitSupport - config bit 0
//   io_out8                - registered readback selected by the SPARE command
module uart_cmd_ctrl #(
    parameter int              FIFO_DEPTH   = 4,
    parameter int              PREDIV_W     = 16,
    parameter logic [PREDIV_W-1:0] PREDIV_RESET = 16'h0068
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          io_in7,
    input  logic                io_strobe,
    input  logic                io_txReady,
    output logic                io_txValid,
    output logic [7:0]          io_txData,
    output logic [PREDIV_W-1:0] io_prediv,
    output logic                io_resetCommandStrobe,
    output logic                io_gatedTxdStopBitSupport,
    output logic [7:0]          io_out8
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] OP_DATA   = 2'd0;
    localparam logic [1:0] OP_CONFIG = 2'd1;
    localparam logic [1:0] OP_PREDIV = 2'd2;
    localparam logic [1:0] OP_SPARE  = 2'd3;

    localparam logic [4:0] P_SOFT_RESET = 5'b11000;

    // Command state
    logic                strobe_d;
    logic [3:0]          nibble_latch;
    logic [3:0]          config_q;
    logic [1:0]          rdsel;
    logic [PREDIV_W-1:0] prediv_shadow;
    logic [7:0]          last_byte;
    logic                overflow;

    // TX queue
    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;

    // Decode
    logic [1:0] opcode;
    logic [4:0] payload;
    logic       fire;
    logic       soft_rst;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] push_byte;

    assign opcode    = io_in7[1:0];
    assign payload   = io_in7[6:2];
    assign fire      = io_strobe && !strobe_d;
    assign soft_rst  = fire && (opcode == OP_CONFIG) && (payload == P_SOFT_RESET);
    assign push_req  = fire && (opcode == OP_DATA) && payload[4];
    assign push_byte = {payload[3:0], nibble_latch};

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = !empty && io_txReady;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_req && (!full || pop) && !soft_rst;

    assign io_txValid = !empty;
    // Head is forced to zero when empty so storage never needs a reset.
    assign io_txData  = empty ? 8'h00 : mem[rd_ptr];
    assign io_gatedTxdStopBitSupport = config_q[0];

    // Status count field saturates at 7 for deeper queues.
    logic [4:0] count_ext;
    logic [2:0] count_sat;
    logic [7:0] readback;

    always_comb begin
        count_ext = 5'(count);
        count_sat = (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];
        readback  = 8'h00;
        case (rdsel)
            2'd0:    readback = {overflow, full, empty, 2'b00, count_sat};
            2'd1:    readback = {4'b0000, config_q};
            2'd2:    readback = io_prediv[7:0];
            default: readback = last_byte;
        endcase
    end

    // Queue storage: no reset, contents are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_d              <= 1'b0;
            nibble_latch          <= '0;
            config_q              <= '0;
            rdsel                 <= '0;
            prediv_shadow         <= '0;
            io_prediv             <= PREDIV_RESET;
            last_byte             <= '0;
            overflow              <= 1'b0;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            count                 <= '0;
            io_resetCommandStrobe <= 1'b0;
            io_out8               <= 8'h20;    // status view of an empty queue
        end else begin
            strobe_d              <= io_strobe;
            io_resetCommandStrobe <= soft_rst;
            io_out8               <= readback;

            if (soft_rst) begin
                // Clear wins over any concurrent pop; prescaler state survives.
                nibble_latch <= '0;
                config_q     <= '0;
                rdsel        <= '0;
                overflow     <= 1'b0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                count        <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push_ok && !pop) begin
                    count <= count + 1'b1;
                end else if (!push_ok && pop) begin
                    count <= count - 1'b1;
                end
                if (push_req && full && !pop) begin
                    overflow <= 1'b1;
                end

                if (fire) begin
                    case (opcode)
                        OP_DATA: begin
                            if (!payload[4]) begin
                                nibble_latch <= payload[3:0];
                            end else begin
                                // Records the commanded byte even when the queue drops it.
                                last_byte <= push_byte;
                            end
                        end
                        OP_CONFIG: begin
                            if (!payload[4]) begin
                                config_q <= payload[3:0];
                            end
                        end
                        OP_PREDIV: begin
                            if (!payload[4]) begin
                                prediv_shadow <= {prediv_shadow[PREDIV_W-5:0], payload[3:0]};
                            end else begin
                                io_prediv <= prediv_shadow;
                            end
                        end
                        default: begin
                            rdsel <= payload[1:0];
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Purpose: self-checking bench for uart_cmd_ctrl against a queue-based command model.
// Latency: model advances once per clock edge; outputs compared 1 time unit after each edge.
// Backpressure: io_txReady driven directed and random; model pops only when its queue is non-empty.
module tb_uart_cmd_ctrl;

    localparam int D  = 4;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    io_in7;
    logic          io_strobe;
    logic          io_txReady;
    logic          io_txValid;
    logic [7:0]    io_txData;
    logic [PW-1:0] io_prediv;
    logic          io_resetCommandStrobe;
    logic          io_gatedTxdStopBitSupport;
    logic [7:0]    io_out8;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .FIFO_DEPTH   (D),
        .PREDIV_W     (PW),
        .PREDIV_RESET (16'h0068)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .io_in7                    (io_in7),
        .io_strobe                 (io_strobe),
        .io_txReady                (io_txReady),
        .io_txValid                (io_txValid),
        .io_txData                 (io_txData),
        .io_prediv                 (io_prediv),
        .io_resetCommandStrobe     (io_resetCommandStrobe),
        .io_gatedTxdStopBitSupport (io_gatedTxdStopBitSupport),
        .io_out8                   (io_out8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus plain command state.
    logic [7:0]    q[$];
    bit            m_ovf;
    logic [3:0]    m_latch;
    logic [3:0]    m_cfg;
    logic [1:0]    m_rdsel;
    logic [PW-1:0] m_shadow;
    logic [PW-1:0] m_prediv;
    logic [7:0]    m_last;
    logic [7:0]    m_out8;
    bit            m_sprev;
    bit            m_rst_pulse;

    function automatic logic [7:0] model_readback();
        int n;
        n = q.size();
        case (m_rdsel)
            2'd0:    return {m_ovf, n == D, n == 0, 2'b00, 3'((n > 7) ? 7 : n)};
            2'd1:    return {4'h0, m_cfg};
            2'd2:    return m_prediv[7:0];
            default: return m_last;
        endcase
    endfunction

    task automatic model_edge();
        logic [1:0] op;
        logic [4:0] p;
        bit         fire;
        bit         pop;
        int         n;
        op = io_in7[1:0];
        p  = io_in7[6:2];
        if (reset) begin
            q.delete();
            m_ovf = 0; m_latch = 0; m_cfg = 0; m_rdsel = 0;
            m_shadow = 0; m_prediv = 16'h0068; m_last = 0;
            m_sprev = 0; m_rst_pulse = 0; m_out8 = 8'h20;
        end else begin
            m_out8      = model_readback();
            fire        = io_strobe && !m_sprev;
            m_sprev     = io_strobe;
            m_rst_pulse = 0;
            pop         = (q.size() > 0) && io_txReady;
            if (fire && op == 2'd1 && p == 5'b11000) begin
                q.delete();
                m_ovf = 0; m_latch = 0; m_cfg = 0; m_rdsel = 0;
                m_rst_pulse = 1;
            end else begin
                n = q.size();
                if (pop) void'(q.pop_front());
                if (fire) begin
                    case (op)
                        2'd0: begin
                            if (p[4]) begin
                                m_last = {p[3:0], m_latch};
                                if (n < D || pop) q.push_back(m_last);
                                else m_ovf = 1;
                            end else begin
                                m_latch = p[3:0];
                            end
                        end
                        2'd1: if (!p[4]) m_cfg = p[3:0];
                        2'd2: begin
                            if (!p[4]) m_shadow = {m_shadow[PW-5:0], p[3:0]};
                            else m_prediv = m_shadow;
                        end
                        default: m_rdsel = p[1:0];
                    endcase
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("txValid", io_txValid, q.size() != 0);
        chk("txData", io_txData, (q.size() != 0) ? q[0] : 8'h00);
        chk("prediv", io_prediv, m_prediv);
        chk("rstStrobe", io_resetCommandStrobe, m_rst_pulse);
        chk("stopBit", io_gatedTxdStopBitSupport, m_cfg[0]);
        chk("out8", io_out8, m_out8);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [4:0] p);
        io_in7    = {p, op};
        io_strobe = 1'b1;
        step();
        io_strobe = 1'b0;
        step();
    endtask

    task automatic push_byte(input logic [7:0] b);
        cmd(2'd0, {1'b0, b[3:0]});
        cmd(2'd0, {1'b1, b[7:4]});
    endtask

    initial begin
        reset = 1'b1; io_in7 = '0; io_strobe = 1'b0; io_txReady = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        chk("reset_out8", io_out8, 8'h20);

        // Nibble assembly: low 5, high A.
        cmd(2'd0, 5'b00101);
        cmd(2'd0, 5'b11010);
        chk("byte_a5", io_txData, 8'hA5);
        chk("status_one", io_out8, 8'h01);

        // Overflow: one byte already queued, four more; the last is dropped.
        for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
        chk("ovf_bit", io_out8[7], 1'b1);
        chk("full_bit", io_out8[6], 1'b1);
        io_txReady = 1'b1;
        repeat (6) step();
        chk("empty_bit", io_out8[5], 1'b1);
        chk("ovf_sticky", io_out8[7], 1'b1);
        io_txReady = 1'b0;

        // Prescaler nibble shift and commit.
        for (int i = 1; i <= 4; i++) cmd(2'd2, 5'(i));
        chk("prediv_hold", io_prediv, 16'h0068);
        io_in7 = {5'b10000, 2'd2}; io_strobe = 1'b1;
        step();
        chk("prediv_1234", io_prediv, 16'h1234);
        io_strobe = 1'b0;
        step();
        cmd(2'd3, 5'd2);
        chk("rd_prediv", io_out8, 8'h34);

        // Config then soft reset.
        cmd(2'd1, 5'b00001);
        chk("stop_on", io_gatedTxdStopBitSupport, 1'b1);
        io_in7 = {5'b11000, 2'd1}; io_strobe = 1'b1;
        step();
        chk("srst_pulse", io_resetCommandStrobe, 1'b1);
        io_strobe = 1'b0;
        step();
        chk("srst_once", io_resetCommandStrobe, 1'b0);
        chk("srst_prediv", io_prediv, 16'h1234);
        chk("srst_stop", io_gatedTxdStopBitSupport, 1'b0);

        // Level-held strobe executes once.
        io_in7 = {5'b10111, 2'd0}; io_strobe = 1'b1;
        repeat (10) step();
        io_strobe = 1'b0;
        step();
        chk("hold_count", io_out8[2:0], 3'd1);
        cmd(2'd1, 5'b10001);

        // Full queue with simultaneous pop and push.
        io_txReady = 1'b1;
        repeat (3) step();
        io_txReady = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
        cmd(2'd0, 5'b01001);
        io_in7 = {5'b10110, 2'd0}; io_strobe = 1'b1; io_txReady = 1'b1;
        step();
        io_strobe = 1'b0; io_txReady = 1'b0;
        step();
        chk("pp_count", io_out8[2:0], 3'd4);
        chk("pp_no_ovf", io_out8[7], 1'b0);
        io_txReady = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        chk("hr_valid", io_txValid, 1'b0);
        chk("hr_prediv", io_prediv, 16'h0068);
        reset = 1'b0; io_txReady = 1'b0;
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            io_in7     = 7'($urandom);
            io_strobe  = $urandom_range(0, 1) == 1;
            io_txReady = $urandom_range(0, 2) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
